// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus sequencer: one load/store at a time over a req/ack bus, big-endian lanes.
// Optional build macro MEM_ALIGN_CHK_EN rejects misaligned halves/words without touching the bus.
module mem_bus_ctrl #(
    parameter int unsigned TO_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [3:0]  mem_i_op,
    input  logic [31:0] mem_i_addr,
    input  logic [31:0] mem_i_sdata,
    input  logic [4:0]  mem_i_waddr,
    output logic        mem_o_stall,
    output logic        bus_o_req,
    output logic        bus_o_we,
    output logic [31:0] bus_o_addr,
    output logic [3:0]  bus_o_sel,
    output logic [31:0] bus_o_wdata,
    input  logic        bus_i_ack,
    input  logic [31:0] bus_i_rdata,
    output logic        mem_o_ld_valid,
    output logic [4:0]  mem_o_ld_waddr,
    output logic [31:0] mem_o_ld_data,
    output logic        mem_o_err
);

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;
    localparam logic [7:0] CntMax = 8'(TO_CYC - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  waddr_q;
    logic [7:0]  cnt_q;
    logic        req_q, we_q, ld_valid_q, err_q;
    logic [31:0] addr_q, wdata_q, ld_data_q;
    logic [3:0]  sel_q;
    logic [4:0]  ld_waddr_q;

    logic        op_valid, is_store, is_byte, is_half, misalign;
    logic        start, abort, ack_hit, timeout;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign op_valid = (mem_i_op >= OpLb) && (mem_i_op <= OpSw);
    assign is_store = (mem_i_op == OpSb) || (mem_i_op == OpSh) || (mem_i_op == OpSw);
    assign is_byte  = (mem_i_op == OpLb) || (mem_i_op == OpLbu) || (mem_i_op == OpSb);
    assign is_half  = (mem_i_op == OpLh) || (mem_i_op == OpLhu) || (mem_i_op == OpSh);

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = is_half ? mem_i_addr[0] : (!is_byte && (mem_i_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Byte lane 0 is the most significant byte of the bus word.
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = mem_i_sdata;
        if (is_byte) begin
            sel_d   = 4'b1000 >> mem_i_addr[1:0];
            wdata_d = {4{mem_i_sdata[7:0]}};
        end else if (is_half) begin
            sel_d   = mem_i_addr[1] ? 4'b0011 : 4'b1100;
            wdata_d = {2{mem_i_sdata[15:0]}};
        end
    end

    always_comb begin
        unique case (lane_q)
            2'd0:    ld_byte = bus_i_rdata[31:24];
            2'd1:    ld_byte = bus_i_rdata[23:16];
            2'd2:    ld_byte = bus_i_rdata[15:8];
            default: ld_byte = bus_i_rdata[7:0];
        endcase
        ld_half = lane_q[1] ? bus_i_rdata[15:0] : bus_i_rdata[31:16];
        case (op_q)
            OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_ext = {24'd0, ld_byte};
            OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_ext = {16'd0, ld_half};
            default: ld_ext = bus_i_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_o_stall = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        ack_hit     = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    mem_o_stall = 1'b1;
                    state_d     = misalign ? StDone : StBusy;
                    abort       = misalign;
                    start       = !misalign;
                end
            end
            StBusy: begin
                mem_o_stall = 1'b1;
                if (bus_i_ack) begin
                    ack_hit = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    timeout = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= StIdle;
            op_q       <= 4'd0;
            lane_q     <= 2'd0;
            waddr_q    <= 5'd0;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            sel_q      <= 4'd0;
            wdata_q    <= 32'd0;
            ld_valid_q <= 1'b0;
            ld_waddr_q <= 5'd0;
            ld_data_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= is_store;
                addr_q  <= {mem_i_addr[31:2], 2'b00};
                sel_q   <= sel_d;
                wdata_q <= wdata_d;
                op_q    <= mem_i_op;
                lane_q  <= mem_i_addr[1:0];
                waddr_q <= mem_i_waddr;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
            if (ack_hit) begin
                req_q <= 1'b0;
                if (!we_q) begin
                    ld_valid_q <= 1'b1;
                    ld_data_q  <= ld_ext;
                    ld_waddr_q <= waddr_q;
                end
            end
            if (timeout) begin
                req_q <= 1'b0;
                err_q <= 1'b1;
            end
            if (state_q == StBusy && !ack_hit && !timeout) begin
                cnt_q <= cnt_q + 8'd1;
            end else if (state_q == StDone) begin
                cnt_q <= 8'd0;
            end
        end
    end

    assign bus_o_req      = req_q;
    assign bus_o_we       = we_q;
    assign bus_o_addr     = addr_q;
    assign bus_o_sel      = sel_q;
    assign bus_o_wdata    = wdata_q;
    assign mem_o_ld_valid = ld_valid_q;
    assign mem_o_ld_waddr = ld_waddr_q;
    assign mem_o_ld_data  = ld_data_q;
    assign mem_o_err      = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: expected access results are queued at issue and
// popped when the access reaches its DONE cycle.
module tb_mem_bus_ctrl;

    localparam int unsigned TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [3:0]  mem_i_op = '0;
    logic [31:0] mem_i_addr = '0;
    logic [31:0] mem_i_sdata = '0;
    logic [4:0]  mem_i_waddr = '0;
    logic        mem_o_stall;
    logic        bus_o_req;
    logic        bus_o_we;
    logic [31:0] bus_o_addr;
    logic [3:0]  bus_o_sel;
    logic [31:0] bus_o_wdata;
    logic        bus_i_ack = 1'b0;
    logic [31:0] bus_i_rdata = '0;
    logic        mem_o_ld_valid;
    logic [4:0]  mem_o_ld_waddr;
    logic [31:0] mem_o_ld_data;
    logic        mem_o_err;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TO_CYC(TO_CYC)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .mem_i_op       (mem_i_op),
        .mem_i_addr     (mem_i_addr),
        .mem_i_sdata    (mem_i_sdata),
        .mem_i_waddr    (mem_i_waddr),
        .mem_o_stall    (mem_o_stall),
        .bus_o_req      (bus_o_req),
        .bus_o_we       (bus_o_we),
        .bus_o_addr     (bus_o_addr),
        .bus_o_sel      (bus_o_sel),
        .bus_o_wdata    (bus_o_wdata),
        .bus_i_ack      (bus_i_ack),
        .bus_i_rdata    (bus_i_rdata),
        .mem_o_ld_valid (mem_o_ld_valid),
        .mem_o_ld_waddr (mem_o_ld_waddr),
        .mem_o_ld_data  (mem_o_ld_data),
        .mem_o_err      (mem_o_err)
    );

    typedef struct {
        int          req_cycles;
        int          stall_cycles;
        logic        unstable;
        logic        hang;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] baddr;
        logic [31:0] wdata;
        logic        valid;
        logic        err;
        logic        done_req;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [3:0]  after;
    } obs_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] baddr;
        logic [31:0] wdata;
        logic        valid;
        logic        err;
        logic [4:0]  waddr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_waddr = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access; ack_at = n acks in the n-th BUSY cycle, 0 never acks.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [4:0] waddr,
                              input int ack_at, input logic [31:0] rdata, output obs_t o);
        int cyc;
        o = '{default: '0};
        mem_i_op = op;
        mem_i_addr = addr;
        mem_i_sdata = sdata;
        mem_i_waddr = waddr;
        #1;
        o.stall_cycles = mem_o_stall ? 1 : 0;
        step();
        cyc = 0;
        while (mem_o_stall && cyc < 300) begin
            o.stall_cycles++;
            if (bus_o_req) begin
                if (o.req_cycles == 0) begin
                    o.we = bus_o_we;
                    o.sel = bus_o_sel;
                    o.baddr = bus_o_addr;
                    o.wdata = bus_o_wdata;
                end else if ({o.we, o.sel, o.baddr, o.wdata} !==
                             {bus_o_we, bus_o_sel, bus_o_addr, bus_o_wdata}) begin
                    o.unstable = 1'b1;
                end
                o.req_cycles++;
            end
            if (cyc + 1 == ack_at) begin
                bus_i_ack = 1'b1;
                bus_i_rdata = rdata;
            end
            step();
            bus_i_ack = 1'b0;
            cyc++;
        end
        o.hang = (cyc >= 300);
        o.valid = mem_o_ld_valid;
        o.err = mem_o_err;
        o.done_req = bus_o_req;
        o.waddr = mem_o_ld_waddr;
        o.data = mem_o_ld_data;
        // Stray ack in DONE must be ignored; the op is withdrawn once the pipeline advances.
        bus_i_ack = 1'b1;
        bus_i_rdata = 32'hA5A5_A5A5;
        mem_i_op = 4'd0;
        step();
        bus_i_ack = 1'b0;
        o.after = {mem_o_ld_valid, mem_o_err, bus_o_req, mem_o_stall};
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [4:0] waddr,
                                   input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] sh;
        int          a;
        a = int'(addr[1:0]);
        e.we = (op >= 4'd6);
        e.baddr = addr & 32'hFFFF_FFFC;
        e.valid = !e.we;
        e.err = 1'b0;
        e.waddr = e.we ? last_waddr : waddr;
        e.data = last_data;
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) begin
            e.sel = 4'b0001 << (3 - a);
            e.wdata = sdata[7:0] * 32'h0101_0101;
            sh = rdata << (8 * a);
            if (op == 4'd1) e.data = $signed(sh) >>> 24;
            if (op == 4'd2) e.data = sh >> 24;
        end else if (op == 4'd3 || op == 4'd4 || op == 4'd7) begin
            e.sel = 4'b1100 >> (2 * int'(addr[1]));
            e.wdata = sdata[15:0] * 32'h0001_0001;
            sh = rdata << (16 * int'(addr[1]));
            if (op == 4'd3) e.data = $signed(sh) >>> 16;
            if (op == 4'd4) e.data = sh >> 16;
        end else begin
            e.sel = 4'b1111;
            e.wdata = sdata;
            if (op == 4'd5) e.data = rdata;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_ = 1'b0;
        #3;
        n_checks++;
        if ({bus_o_req, mem_o_stall, mem_o_ld_valid, mem_o_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus_o_req, mem_o_stall, mem_o_ld_valid, mem_o_err});
        end
        n_checks++;
        if ({bus_o_addr, bus_o_sel, bus_o_wdata, mem_o_ld_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero",
                     bus_o_addr, bus_o_sel, bus_o_wdata, mem_o_ld_data);
        end
        step();
        rst_ = 1'b1;
        step();
        n_checks++;
        if ({bus_o_req, mem_o_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_none: got %b expected 00", {bus_o_req, mem_o_stall});
        end
    endtask

    task automatic test_lw();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(4'd5, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF));
        run_access(4'd5, 32'h100, 32'h0, 5'd5, 2, 32'hDEAD_BEEF, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.req_cycles !== 2 || o.stall_cycles !== 3) begin
            n_fail++;
            $display("FAIL lw_cycles: got req %0d stall %0d expected req 2 stall 3",
                     o.req_cycles, o.stall_cycles);
        end
        n_checks++;
        if ({o.we, o.sel, o.baddr} !== {1'b0, 4'b1111, 32'h100}) begin
            n_fail++;
            $display("FAIL lw_bus: got we %b sel %b addr %h expected 0 1111 00000100",
                     o.we, o.sel, o.baddr);
        end
        n_checks++;
        if ({o.valid, o.err, o.waddr, o.data} !== {e.valid, e.err, e.waddr, e.data}) begin
            n_fail++;
            $display("FAIL lw_result: got v%b e%b w%0d %h expected v%b e%b w%0d %h", o.valid,
                     o.err, o.waddr, o.data, e.valid, e.err, e.waddr, e.data);
        end
        n_checks++;
        if (o.after !== 4'b0000 || o.done_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_after: got %b req %b expected 0000 req 0", o.after, o.done_req);
        end
        last_data = 32'hDEAD_BEEF;
        last_waddr = 5'd5;
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(4'd1, 32'h103, 32'h0, 5'd7, 32'h1234_56F0));
        run_access(4'd1, 32'h103, 32'h0, 5'd7, 1, 32'h1234_56F0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.sel !== 4'b0001 || o.data !== 32'hFFFF_FFF0 || o.data !== e.data) begin
            n_fail++;
            $display("FAIL lb_sext: got sel %b data %h expected 0001 fffffff0", o.sel, o.data);
        end
        last_data = 32'hFFFF_FFF0;
        last_waddr = 5'd7;
        exp_q.push_back(model(4'd2, 32'h103, 32'h0, 5'd8, 32'h1234_56F0));
        run_access(4'd2, 32'h103, 32'h0, 5'd8, 3, 32'h1234_56F0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.sel !== 4'b0001 || o.data !== 32'h0000_00F0 || o.valid !== 1'b1 ||
            o.waddr !== 5'd8) begin
            n_fail++;
            $display("FAIL lbu_zext: got sel %b data %h v%b w%0d expected 0001 000000f0 v1 w8",
                     o.sel, o.data, o.valid, o.waddr);
        end
        last_data = e.data;
        last_waddr = 5'd8;
    endtask

    task automatic test_sh();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(4'd7, 32'h202, 32'hABCD_1234, 5'd9, 32'h0));
        run_access(4'd7, 32'h202, 32'hABCD_1234, 5'd9, 2, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++;
        if ({o.we, o.sel, o.baddr, o.wdata} !== {1'b1, 4'b0011, 32'h200, 32'h1234_1234}) begin
            n_fail++;
            $display("FAIL sh_bus: got we %b sel %b addr %h wdata %h expected 1 0011 200 12341234",
                     o.we, o.sel, o.baddr, o.wdata);
        end
        n_checks++;
        if ({o.valid, o.err, o.waddr, o.data} !== {1'b0, 1'b0, e.waddr, e.data}) begin
            n_fail++;
            $display("FAIL sh_result: got v%b e%b w%0d %h expected v0 e0 w%0d %h",
                     o.valid, o.err, o.waddr, o.data, e.waddr, e.data);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        e = model(4'd5, 32'h400, 32'h0, 5'd3, 32'h0);
        e.valid = 1'b0;
        e.err = 1'b1;
        e.waddr = last_waddr;
        e.data = last_data;
        exp_q.push_back(e);
        run_access(4'd5, 32'h400, 32'h0, 5'd3, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.req_cycles !== int'(TO_CYC) || o.hang) begin
            n_fail++;
            $display("FAIL to_req_cycles: got %0d hang %b expected %0d",
                     o.req_cycles, o.hang, TO_CYC);
        end
        n_checks++;
        if ({o.valid, o.err, o.done_req, o.data} !== {e.valid, e.err, 1'b0, e.data}) begin
            n_fail++;
            $display("FAIL to_result: got v%b e%b req%b %h expected v0 e1 req0 %h",
                     o.valid, o.err, o.done_req, o.data, e.data);
        end
        n_checks++;
        if (o.after !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_after: got %b expected 0000", o.after);
        end
    endtask

    task automatic test_reset_mid_busy();
        mem_i_op = 4'd5;
        mem_i_addr = 32'h300;
        step();
        step();
        n_checks++;
        if ({bus_o_req, mem_o_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_busy_pre: got %b expected 11", {bus_o_req, mem_o_stall});
        end
        rst_ = 1'b0;
        mem_i_op = 4'd0;
        #1;
        n_checks++;
        if ({bus_o_req, mem_o_stall, mem_o_ld_valid, mem_o_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_busy_drop: got %b expected 0000",
                     {bus_o_req, mem_o_stall, mem_o_ld_valid, mem_o_err});
        end
        step();
        rst_ = 1'b1;
        step();
        bus_i_ack = 1'b1;
        bus_i_rdata = 32'h5555_5555;
        step();
        bus_i_ack = 1'b0;
        n_checks++;
        if ({bus_o_req, mem_o_stall, mem_o_ld_valid, mem_o_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_busy_ack: got %b expected 0000",
                     {bus_o_req, mem_o_stall, mem_o_ld_valid, mem_o_err});
        end
        last_data = 32'h0;
        last_waddr = 5'd0;
    endtask

    task automatic test_align();
        obs_t o;
        exp_t e;
`ifdef MEM_ALIGN_CHK_EN
        e = model(4'd5, 32'h101, 32'h0, 5'd4, 32'h0);
        e.valid = 1'b0;
        e.err = 1'b1;
        e.waddr = last_waddr;
        e.data = last_data;
        exp_q.push_back(e);
        run_access(4'd5, 32'h101, 32'h0, 5'd4, 1, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.req_cycles !== 0 || o.stall_cycles !== 1 || o.err !== e.err ||
            o.valid !== e.valid) begin
            n_fail++;
            $display("FAIL align_err: got req %0d stall %0d e%b v%b expected 0 1 e1 v0",
                     o.req_cycles, o.stall_cycles, o.err, o.valid);
        end
`else
        exp_q.push_back(model(4'd5, 32'h101, 32'h0, 5'd4, 32'h0BAD_F00D));
        run_access(4'd5, 32'h101, 32'h0, 5'd4, 1, 32'h0BAD_F00D, o);
        e = exp_q.pop_front();
        n_checks++;
        if ({o.baddr, o.sel, o.valid, o.err, o.data} !==
            {32'h100, 4'b1111, 1'b1, 1'b0, 32'h0BAD_F00D}) begin
            n_fail++;
            $display("FAIL align_none: got %h %b v%b e%b %h expected 100 1111 v1 e0 0badf00d",
                     o.baddr, o.sel, o.valid, o.err, o.data);
        end
        last_data = e.data;
        last_waddr = 5'd4;
`endif
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  waddr;
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(1, 8));
            addr = $urandom;
            if (op == 4'd5 || op == 4'd8) addr[1:0] = 2'b00;
            if (op == 4'd3 || op == 4'd4 || op == 4'd7) addr[0] = 1'b0;
            sdata = $urandom;
            rdata = $urandom;
            waddr = 5'($urandom);
            exp_q.push_back(model(op, addr, sdata, waddr, rdata));
            run_access(op, addr, sdata, waddr, int'($urandom_range(1, 4)), rdata, o);
            e = exp_q.pop_front();
            n_checks++;
            if ({o.we, o.sel, o.baddr} !== {e.we, e.sel, e.baddr} || o.unstable ||
                (e.we && o.wdata !== e.wdata)) begin
                n_fail++;
                $display("FAIL rand_bus op%0d: got we%b %b %h %h unst%b expected we%b %b %h %h",
                         op, o.we, o.sel, o.baddr, o.wdata, o.unstable, e.we, e.sel, e.baddr,
                         e.wdata);
            end
            n_checks++;
            if ({o.valid, o.err, o.waddr, o.data} !== {e.valid, e.err, e.waddr, e.data}) begin
                n_fail++;
                $display("FAIL rand_result op%0d a%h: got v%b e%b w%0d %h expected v%b e%b w%0d %h",
                         op, addr, o.valid, o.err, o.waddr, o.data, e.valid, e.err, e.waddr,
                         e.data);
            end
            last_data = e.data;
            last_waddr = e.waddr;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_timeout();
        test_reset_mid_busy();
        test_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
